// File: rtl/nn_seq_pkg.sv
// Shared types and default widths for the nibble-loaded MAC sequencer.
// Register widths are derived from the operand width, term count and vector count.
package nn_seq_pkg;

  localparam int DEF_NIB_W   = 4;
  localparam int DEF_N_TERMS = 8;
  localparam int DEF_N_VEC   = 4;
  localparam int DEF_ACC_W   = 12;

  localparam int DEF_W_REG_W = DEF_NIB_W * DEF_N_TERMS;
  localparam int DEF_D_REG_W = DEF_W_REG_W * DEF_N_VEC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_W    = 2'b01,
    SEL_D    = 2'b10,
    SEL_CLR  = 2'b11
  } nib_sel_t;

endpackage

// File: rtl/nn_mac_unit.sv
// Signed NIB_W x NIB_W multiplier feeding an ACC_W accumulator.
// Synchronous clear takes priority over enable.
module nn_mac_unit
  import nn_seq_pkg::*;
#(
  parameter int NIB_W = DEF_NIB_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [NIB_W-1:0] a,
  input  logic signed [NIB_W-1:0] b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*NIB_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W - 2*NIB_W){prod[2*NIB_W-1]}}, prod};

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/nn_mac_sequencer.sv
// Loads weight/data registers nibble-wise, then runs N_VEC dot products on one MAC.
// Build option: define NN_MAC_SEQ_RELU_EN to clamp negative results to zero.
module nn_mac_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NIB_W   = DEF_NIB_W,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int N_VEC   = DEF_N_VEC,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NIB_W-1:0] nib_in,
  input  logic [1:0]       nib_sel,
  input  logic             nib_valid,
  input  logic             start,
  output logic             busy,
  output logic             res_valid,
  output logic [1:0]       res_idx,
  output logic [ACC_W-1:0] res,
  output logic             done,
  output logic             load_err
);

  localparam int W_REG_W = NIB_W * N_TERMS;
  localparam int D_REG_W = W_REG_W * N_VEC;
  localparam int K_W     = $clog2(N_TERMS);

  localparam logic [K_W-1:0] K_LAST = K_W'(N_TERMS - 1);
  localparam logic [1:0]     V_LAST = 2'(N_VEC - 1);

  state_t state, state_nxt;

  logic [W_REG_W-1:0] weight_reg;
  logic [D_REG_W-1:0] data_reg;
  logic [K_W-1:0]     k_cnt;
  logic [1:0]         v_cnt;
  logic               load_err_q;
  logic [ACC_W-1:0]   res_hold;
  logic [1:0]         idx_hold;

  logic                    mac_clr;
  logic                    mac_en;
  logic signed [NIB_W-1:0] w_op;
  logic signed [NIB_W-1:0] d_op;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]        res_val;

  logic     is_idle;
  logic     load_req;
  nib_sel_t sel;

  assign is_idle  = (state == ST_IDLE);
  assign sel      = nib_sel_t'(nib_sel);
  assign load_req = nib_valid && (sel != SEL_NONE);

  // Operand k of the weight vector and of the current data vector.
  assign w_op = weight_reg[int'(k_cnt)*NIB_W +: NIB_W];
  assign d_op = data_reg[(int'(v_cnt)*N_TERMS + int'(k_cnt))*NIB_W +: NIB_W];

  nn_mac_unit #(
    .NIB_W (NIB_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mac_clr),
    .en    (mac_en),
    .a     (w_op),
    .b     (d_op),
    .acc   (acc)
  );

  // NOTE: the operand registers are plain flops, not a RAM, so they are reset
  // directly; a mid-run reset must leave them cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_reg <= '0;
      data_reg   <= '0;
      load_err_q <= 1'b0;
    end else if (load_req) begin
      if (is_idle) begin
        case (sel)
          SEL_W:   weight_reg <= {weight_reg[W_REG_W-NIB_W-1:0], nib_in};
          SEL_D:   data_reg   <= {data_reg[D_REG_W-NIB_W-1:0], nib_in};
          SEL_CLR: begin
            weight_reg <= '0;
            data_reg   <= '0;
            load_err_q <= 1'b0;
          end
          default: ;
        endcase
      end else begin
        load_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          mac_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        mac_en = 1'b1;
        if (k_cnt == K_LAST) state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (v_cnt == V_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RUN;
          mac_clr   = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_cnt <= '0;
      v_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            k_cnt <= '0;
            v_cnt <= '0;
          end
        end
        ST_RUN:  k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + K_W'(1);
        ST_EMIT: begin
          k_cnt <= '0;
          if (v_cnt != V_LAST) v_cnt <= v_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef NN_MAC_SEQ_RELU_EN
  assign res_val = acc[ACC_W-1] ? '0 : acc;
`else
  assign res_val = acc;
`endif

  // Result pins show the live accumulator during EMIT and hold it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_hold <= '0;
      idx_hold <= '0;
    end else if (state == ST_EMIT) begin
      res_hold <= res_val;
      idx_hold <= v_cnt;
    end
  end

  assign busy      = !is_idle;
  assign res_valid = (state == ST_EMIT);
  assign done      = (state == ST_DONE);
  assign res       = res_valid ? res_val : res_hold;
  assign res_idx   = res_valid ? v_cnt : idx_hold;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Scoreboard bench for nn_mac_sequencer: expected dot products are queued at start
// and popped on every res_valid; cycle timing of busy/res_valid/done is checked per cycle.
module tb_nn_mac_sequencer;
  import nn_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  nib_in = '0;
  logic [1:0]  nib_sel = '0;
  logic        nib_valid = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_idx;
  logic [11:0] res;
  logic        done;
  logic        load_err;

  nn_mac_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nib_in    (nib_in),
    .nib_sel   (nib_sel),
    .nib_valid (nib_valid),
    .start     (start),
    .busy      (busy),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res       (res),
    .done      (done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic [11:0] val;
  } exp_t;

  exp_t        sb[$];
  int          w_m[8];
  int          d_m[4][8];
  logic [11:0] last_res = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_dot(input int v);
    int s = 0;
    for (int k = 0; k < 8; k++) s += w_m[k] * d_m[v][k];
`ifdef NN_MAC_SEQ_RELU_EN
    if (s < 0) s = 0;
`endif
    return 12'(s);
  endfunction

  task automatic push_expected();
    for (int v = 0; v < 4; v++) sb.push_back('{idx: 2'(v), val: model_dot(v)});
  endtask

  task automatic set_model(input int wv, input int dv, input bit ramp);
    for (int k = 0; k < 8; k++) begin
      w_m[k] = wv;
      for (int v = 0; v < 4; v++) d_m[v][k] = ramp ? v + 1 : dv;
    end
  endtask

  task automatic load_nib(input logic [1:0] sel, input logic [3:0] nib);
    @(negedge clk);
    nib_valid = 1'b1;
    nib_sel   = sel;
    nib_in    = nib;
    @(posedge clk);
    #1 nib_valid = 1'b0;
  endtask

  // First nibble shifted in ends up most significant, so load highest index first.
  task automatic load_all();
    for (int k = 7; k >= 0; k--) load_nib(2'b01, 4'(w_m[k]));
    for (int v = 3; v >= 0; v--)
      for (int k = 7; k >= 0; k--) load_nib(2'b10, 4'(d_m[v][k]));
  endtask

  // Cycle n is observed on the negedge just before edge Tn.
  task automatic run_cycles(input bit inject, input bit hold, input int last);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      nib_valid = 1'b0;
      if (inject && n == 5) begin
        nib_valid = 1'b1;
        nib_sel   = 2'b01;
        nib_in    = 4'hF;
      end
      if (inject && n == 6) start = 1'b1;
      check("busy", 32'(busy), 32'd1);
      check("res_valid", 32'(res_valid), 32'(n % 9 == 0 && n <= 36));
      check("done", 32'(done), 32'(n == 37));
      if (res_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res", 32'(res), 32'(e.val));
          check("res_idx", 32'(res_idx), 32'(e.idx));
          last_res = e.val;
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic idle_checks();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_res_valid", 32'(res_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("res_hold", 32'(res), 32'(last_res));
  endtask

  task automatic start_run(input bit hold, input bit inject);
    @(negedge clk);
    start = 1'b1;
    push_expected();
    @(posedge clk);
    run_cycles(inject, hold, 37);
    @(negedge clk);
    start = hold;
    idle_checks();
    if (hold) begin
      push_expected();
      @(posedge clk);
      run_cycles(1'b0, 1'b0, 37);
      @(negedge clk);
      start = 1'b0;
      idle_checks();
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_load_err"}, 32'(load_err), 32'd0);
    check({tag, "_res"}, 32'(res), 32'd0);
    check({tag, "_res_idx"}, 32'(res_idx), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a load sequence clears everything.
    set_model(3, 5, 1'b0);
    for (int k = 7; k >= 4; k--) load_nib(2'b01, 4'(w_m[k]));
    load_nib(2'b10, 4'h5);
    @(negedge clk);
    rst_n = 1'b0;
    #1 reset_checks("rst_load");
    @(negedge clk);
    rst_n = 1'b1;
    set_model(0, 0, 1'b0);
    last_res = '0;
    start_run(1'b0, 1'b0);

    // Basic: unit weights, vector v elements = v+1 -> 8/16/24/32.
    set_model(1, 0, 1'b1);
    load_all();
    start_run(1'b0, 1'b0);

    // Signed: -8 x 7 -> -448 (0 with ReLU), then -8 x -8 -> 512.
    set_model(-8, 7, 1'b0);
    load_all();
    start_run(1'b0, 1'b0);
    set_model(-8, -8, 1'b0);
    load_all();
    start_run(1'b0, 1'b0);

    // Load at T5 and start at T6 during a run are ignored; load_err latches.
    check("load_err_before", 32'(load_err), 32'd0);
    start_run(1'b0, 1'b1);
    check("load_err_busy", 32'(load_err), 32'd1);

    // Clear in IDLE wipes both registers and load_err.
    load_nib(2'b11, 4'h0);
    check("load_err_clr", 32'(load_err), 32'd0);
    set_model(0, 0, 1'b0);
    start_run(1'b0, 1'b0);

    // Mixed-sign pattern to exercise per-term indexing.
    for (int k = 0; k < 8; k++) begin
      w_m[k] = k - 4;
      for (int v = 0; v < 4; v++) d_m[v][k] = (v * 3 + k) % 16 - 8;
    end
    load_all();
    start_run(1'b0, 1'b0);

    // Reset mid-run at T12: immediate abort, no done, registers cleared.
    set_model(1, 0, 1'b1);
    load_all();
    @(negedge clk);
    start = 1'b1;
    push_expected();
    @(posedge clk);
    run_cycles(1'b0, 1'b0, 11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    set_model(0, 0, 1'b0);
    last_res = '0;
    start_run(1'b0, 1'b0);

    // Back-to-back: start held high, second run begins at T38.
    set_model(1, 0, 1'b1);
    load_all();
    start_run(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
